// File: rtl/pipe_pkg.sv
// Shared pipeline constants: default field widths and the packed payload layout
// used by the decode-to-execute stage.
package pipe_pkg;

  localparam int DEF_XLEN     = 32;
  localparam int DEF_NUM_OPS  = 4;
  localparam int DEF_ALU_OP_W = 4;
  localparam int DEF_RD_W     = 5;

  // Flags occupy the low bits of every payload, so their positions never move
  // when operand count or widths change. Above them: rd, alu_op, then operands.
  localparam int NUM_FLAGS = 4;

  typedef enum int unsigned {
    FLAG_BRN = 0,
    FLAG_WE  = 1,
    FLAG_STR = 2,
    FLAG_LD  = 3
  } flag_pos_e;

  function automatic int payload_width(input int num_ops, input int xlen,
                                       input int alu_op_w, input int rd_w);
    return num_ops * xlen + alu_op_w + rd_w + NUM_FLAGS;
  endfunction

  localparam int PAYLOAD_W = payload_width(DEF_NUM_OPS, DEF_XLEN, DEF_ALU_OP_W, DEF_RD_W);

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (clr) begin
      cnt_next = '0;
    end else if (en && (cnt_reg != {CNT_W{1'b1}})) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    cnt_reg <= cnt_next;
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/d_ex_skid_stage.sv
// Decode-to-execute stage with valid/ready handshake and a 2-entry skid buffer.
// Optional perf counters (stall_cnt, bubble_cnt) are built when PIPE_PERF_CNT_EN is defined.
module d_ex_skid_stage
  import pipe_pkg::*;
#(
  parameter int XLEN     = DEF_XLEN,
  parameter int NUM_OPS  = DEF_NUM_OPS,
  parameter int ALU_OP_W = DEF_ALU_OP_W,
  parameter int RD_W     = DEF_RD_W
`ifdef PIPE_PERF_CNT_EN
  ,
  parameter int CNT_W    = 32
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    D_valid,
  output logic                    D_ready,
  input  logic [NUM_OPS*XLEN-1:0] D_ops,
  input  logic [ALU_OP_W-1:0]     D_alu_op,
  input  logic [RD_W-1:0]         D_rd,
  input  logic                    D_ld,
  input  logic                    D_str,
  input  logic                    D_we,
  input  logic                    D_brn,
  input  logic                    flush,
  output logic                    EX_valid,
  input  logic                    EX_ready,
  output logic [NUM_OPS*XLEN-1:0] EX_ops,
  output logic [ALU_OP_W-1:0]     EX_alu_op,
  output logic [RD_W-1:0]         EX_rd,
  output logic                    EX_ld,
  output logic                    EX_str,
  output logic                    EX_we,
  output logic                    EX_brn
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]        stall_cnt,
  output logic [CNT_W-1:0]        bubble_cnt
`endif
);

  localparam int OPS_W   = NUM_OPS * XLEN;
  localparam int SLOT_W  = payload_width(NUM_OPS, XLEN, ALU_OP_W, RD_W);
  localparam int RD_LSB  = NUM_FLAGS;
  localparam int ALU_LSB = RD_LSB + RD_W;
  localparam int OPS_LSB = ALU_LSB + ALU_OP_W;

  logic              main_valid_reg, main_valid_next;
  logic              skid_valid_reg, skid_valid_next;
  logic [SLOT_W-1:0] main_data_reg, main_data_next;
  logic [SLOT_W-1:0] skid_data_reg, skid_data_next;
  logic [SLOT_W-1:0] d_payload;
  logic [SLOT_W-1:0] ex_payload;
  logic              accept;
  logic              emit;

  always_comb begin
    d_payload                       = '0;
    d_payload[OPS_LSB +: OPS_W]     = D_ops;
    d_payload[ALU_LSB +: ALU_OP_W]  = D_alu_op;
    d_payload[RD_LSB +: RD_W]       = D_rd;
    d_payload[FLAG_LD]              = D_ld;
    d_payload[FLAG_STR]             = D_str;
    d_payload[FLAG_WE]              = D_we;
    d_payload[FLAG_BRN]             = D_brn;
  end

  // Ready depends only on state (and rst), never on EX_ready.
  assign D_ready = !skid_valid_reg && !rst;
  assign accept  = D_valid && D_ready;
  assign emit    = main_valid_reg && EX_ready;

  always_comb begin
    main_valid_next = main_valid_reg;
    main_data_next  = main_data_reg;
    skid_valid_next = skid_valid_reg;
    skid_data_next  = skid_data_reg;
    if (flush) begin
      main_valid_next = 1'b0;
      main_data_next  = '0;
      skid_valid_next = 1'b0;
      skid_data_next  = '0;
    end else if (!main_valid_reg || emit) begin
      if (skid_valid_reg) begin
        main_valid_next = 1'b1;
        main_data_next  = skid_data_reg;
      end else if (accept) begin
        main_valid_next = 1'b1;
        main_data_next  = d_payload;
      end else begin
        main_valid_next = 1'b0;
        main_data_next  = '0;
      end
      skid_valid_next = 1'b0;
      skid_data_next  = '0;
    end else if (accept) begin
      skid_valid_next = 1'b1;
      skid_data_next  = d_payload;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_reg <= 1'b0;
      main_data_reg  <= '0;
      skid_valid_reg <= 1'b0;
      skid_data_reg  <= '0;
    end else begin
      main_valid_reg <= main_valid_next;
      main_data_reg  <= main_data_next;
      skid_valid_reg <= skid_valid_next;
      skid_data_reg  <= skid_data_next;
    end
  end

  // Bubbles must look like NOPs downstream, so the payload is masked by valid.
  assign ex_payload = main_data_reg & {SLOT_W{main_valid_reg}};
  assign EX_valid   = main_valid_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OPS; gi++) begin : g_ex_ops
      assign EX_ops[gi*XLEN +: XLEN] = ex_payload[OPS_LSB + gi*XLEN +: XLEN];
    end
  endgenerate

  assign EX_alu_op = ex_payload[ALU_LSB +: ALU_OP_W];
  assign EX_rd     = ex_payload[RD_LSB +: RD_W];
  assign EX_ld     = ex_payload[FLAG_LD];
  assign EX_str    = ex_payload[FLAG_STR];
  assign EX_we     = ex_payload[FLAG_WE];
  assign EX_brn    = ex_payload[FLAG_BRN];

`ifdef PIPE_PERF_CNT_EN
  logic stall_en;
  logic bubble_en;

  assign stall_en  = main_valid_reg && !EX_ready;
  assign bubble_en = !main_valid_reg;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .clr (rst),
    .en  (stall_en),
    .cnt (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk (clk),
    .clr (rst),
    .en  (bubble_en),
    .cnt (bubble_cnt)
  );
`endif

endmodule
